alu_issue: RTL

//   Issue stage that drives the ALU. Accepts one decoded-register RV32I instruction
//   per beat (instr, pc, rs1/rs2 data) over a valid/ready handshake.

---
 rtl/alu_issue_pkg.sv | 35 +++
 rtl/alu_issue_if.sv | 27 ++
 rtl/alu_issue_skid_buffer.sv | 59 +++++
 rtl/alu_issue.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage.
// Holds RV32I opcodes, ALU operation codes and the issued-beat bundle.
package alu_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_LSL    = 4'd2,
    ALU_LT     = 4'd3,
    ALU_LTU    = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_LSR    = 4'd6,
    ALU_ASR    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_1 = 4'd10
  } alu_op_e;

  typedef struct packed {
    alu_op_e         operation;
    logic [XLEN-1:0] in_0;
    logic [XLEN-1:0] in_1;
    logic            inv_zero;
    logic            illegal;
  } iss_t;

endpackage

// File: rtl/alu_issue_if.sv
// Handshake bundle between register read, the issue stage and the ALU.
// master drives the upstream beat and downstream ready; slave is the stage.
interface alu_issue_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      operation;
  logic [XLEN-1:0] in_0;
  logic [XLEN-1:0] in_1;
  logic            inv_zero;
  logic            illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, operation, in_0, in_1, inv_zero, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, operation, in_0, in_1, inv_zero, illegal
  );
endinterface

// File: rtl/alu_issue_skid_buffer.sv
// Two-entry registered valid/ready buffer (main + skid).
// in_ready is registered so upstream never sees a combinational path from out_ready.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_vld;
  logic [WIDTH-1:0] main_q;
  logic             skid_vld;
  logic [WIDTH-1:0] skid_q;
  logic             rdy_q;
  logic             accept;
  logic             drain;

  assign accept    = in_valid && rdy_q;
  assign drain     = main_vld && out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = main_vld;
  assign out_data  = main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      main_q   <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
      rdy_q    <= 1'b1;
    end else begin
      if (!main_vld || drain) begin
        // skid holds the older beat, so it always refills main first
        if (skid_vld) begin
          main_q   <= skid_q;
          main_vld <= 1'b1;
          skid_vld <= 1'b0;
          rdy_q    <= 1'b1;
        end else if (accept) begin
          main_q   <= in_data;
          main_vld <= 1'b1;
        end else begin
          main_vld <= 1'b0;
        end
      end else if (accept) begin
        skid_q   <= in_data;
        skid_vld <= 1'b1;
        rdy_q    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_issue.sv
// RV32I issue stage: decodes ALU-class instructions into op + operands,
// then registers the result through a two-entry skid buffer.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_issue_if.slave   bus
);

  function automatic alu_op_e alu_map(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_LSL;
      3'b010: op = ALU_LT;
      3'b011: op = ALU_LTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_ASR : ALU_LSR;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic iss_t decode(
    input logic [31:0] ins,
    input logic [31:0] pc_v,
    input logic [31:0] rs1,
    input logic [31:0] rs2
  );
    iss_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    d         = '0;
    d.operation = ALU_ADD;
    f3        = ins[14:12];
    f7        = ins[31:25];
    imm_i     = {{20{ins[31]}}, ins[31:20]};
    imm_u     = {ins[31:12], 12'b0};
    unique case (ins[6:0])
      OPC_OP: begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          d.operation = alu_map(f3, ins[30]);
          d.in_0      = rs1;
          d.in_1      = rs2;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d.in_0 = rs1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          d.operation = alu_map(f3, ins[30]);
          d.in_1      = {27'b0, ins[24:20]};
        end else begin
          // immediate forms never subtract
          d.operation = alu_map(f3, 1'b0);
          d.in_1      = imm_i;
        end
      end
      OPC_LUI: begin
        d.operation = ALU_PASS_1;
        d.in_1      = imm_u;
      end
      OPC_AUIPC: begin
        d.in_0 = pc_v;
        d.in_1 = imm_u;
      end
      OPC_BRANCH: begin
        d.in_0 = rs1;
        d.in_1 = rs2;
        unique case (f3)
          3'b000: d.operation = ALU_SUB;
          3'b001: begin d.operation = ALU_SUB; d.inv_zero = 1'b1; end
          3'b100: begin d.operation = ALU_LT;  d.inv_zero = 1'b1; end
          3'b101: d.operation = ALU_LT;
          3'b110: begin d.operation = ALU_LTU; d.inv_zero = 1'b1; end
          3'b111: d.operation = ALU_LTU;
          default: begin
            d         = '0;
            d.illegal = 1'b1;
          end
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  iss_t dec;
  iss_t q;

  assign dec = decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);

  skid_buffer #(.WIDTH($bits(iss_t))) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (dec),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (q)
  );

  assign bus.operation = q.operation;
  assign bus.in_0      = q.in_0;
  assign bus.in_1      = q.in_1;
  assign bus.inv_zero  = q.inv_zero;
  assign bus.illegal   = q.illegal;

endmodule
